// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core data-port bundle between load/store unit and data memory
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;
  modport master (output memread, memwrite, addr, writedata, input readdata, stall, err);
  modport slave (input memread, memwrite, addr, writedata, output readdata, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM answering core loads/stores after LATENCY cycles; DMEM_WBUF_EN adds a posted write buffer
module dmem_responder #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 3,
  parameter string INIT_FILE = ""
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic err_q, wr, rd, req, okay, go, done;
  logic capture, busy, drain_err, mem_we;
  logic [AW-1:0] mem_wi;
  logic [31:0] mem_wd;
  function automatic logic in_map(input logic [31:0] a);
    return a[1:0] == 2'b00 && {2'b00, a[31:2]} < 32'(DEPTH);
  endfunction
  assign wr   = bus.memwrite;
  assign rd   = bus.memread & ~bus.memwrite;
  assign req  = rd | wr;
  assign okay = in_map(bus.addr);
`ifdef DMEM_WBUF_EN
  logic          wb_valid, drain;
  logic [31:0]   wb_addr, wb_data;
  logic [CW-1:0] wb_cnt;
  assign busy      = wb_valid;
  assign capture   = state == IDLE && wr && !wb_valid;
  assign drain     = wb_valid && wb_cnt == CW'(1);
  assign drain_err = drain && !in_map(wb_addr);
  assign mem_we    = drain && in_map(wb_addr);
  assign mem_wi    = wb_addr[AW+1:2];
  assign mem_wd    = wb_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_cnt   <= '0;
    end else if (capture) begin
      wb_valid <= 1'b1;
      wb_addr  <= bus.addr;
      wb_data  <= bus.writedata;
      wb_cnt   <= CW'(LATENCY);
    end else if (wb_valid) begin
      wb_cnt   <= wb_cnt - CW'(1);
      wb_valid <= !drain;
    end
  end
`else
  assign busy      = 1'b0;
  assign capture   = 1'b0;
  assign drain_err = 1'b0;
  assign mem_we    = done && wr && okay;
  assign mem_wi    = bus.addr[AW+1:2];
  assign mem_wd    = bus.writedata;
`endif
  assign go = state == IDLE && req && !busy && !capture;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    case (state)
      IDLE: if (go) begin
        done    = LATENCY == 1;
        state_n = LATENCY == 1 ? RESP : WAIT;
        cnt_n   = CW'(LATENCY - 1);
      end
      WAIT: begin
        cnt_n   = cnt - CW'(1);
        done    = cnt == CW'(1);
        state_n = done ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (done && rd) rd_q <= okay ? mem[bus.addr[AW+1:2]] : '0;
      err_q <= (done && !okay) || drain_err;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wi] <= mem_wd;
  end
  assign bus.readdata = rd_q;
  assign bus.err      = err_q;
  assign bus.stall    = (state == IDLE && req && !capture) || state == WAIT;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for LATENCY=3 and LATENCY=1 responders
module tb_dmem_responder;
`ifdef DMEM_WBUF_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  typedef struct packed {logic [31:0] rd; logic e;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q0[$], q1[$];
  exp_t x0, x1;
  logic [31:0] last [2];
  logic ps0 = 1'b0;
  logic ps1 = 1'b0;
  dmem_responder_if b0();
  dmem_responder_if b1();
  dmem_responder #(.DEPTH(256), .LATENCY(3)) u0 (.clk(clk), .reset(reset), .bus(b0));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // a RESP cycle shows up as stall falling after a stalled cycle
  always @(negedge clk) begin
    if (reset) ps0 = 1'b0;
    else begin
      if (ps0 && !b0.stall) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp0_unexpected actual=%0h required=none", b0.readdata);
        end else begin
          x0 = q0.pop_front();
          chk("resp0_readdata", b0.readdata, x0.rd);
          chk("resp0_err", {31'b0, b0.err}, {31'b0, x0.e});
        end
      end
      ps0 = b0.stall;
    end
  end
  always @(negedge clk) begin
    if (reset) ps1 = 1'b0;
    else begin
      if (ps1 && !b1.stall) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp1_unexpected actual=%0h required=none", b1.readdata);
        end else begin
          x1 = q1.pop_front();
          chk("resp1_readdata", b1.readdata, x1.rd);
          chk("resp1_err", {31'b0, b1.err}, {31'b0, x1.e});
        end
      end
      ps1 = b1.stall;
    end
  end
  task automatic push(input int s, input logic [31:0] r, input logic e);
    exp_t x;
    x.rd = r;
    x.e = e;
    if (s == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask
  task automatic acc(input int s, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic e, input int exp_st);
    int n = 0;
    if (s == 0) begin
      b0.memread = rd; b0.memwrite = wr; b0.addr = a; b0.writedata = d;
    end else begin
      b1.memread = rd; b1.memwrite = wr; b1.addr = a; b1.writedata = d;
    end
    if (!wr) last[s] = exp_rd;
    if (!(wr && WB)) push(s, last[s], e);
    @(negedge clk);
    while ((s == 0 ? b0.stall : b1.stall) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("stall_len%0d_%0h", s, a), n, exp_st);
    @(posedge clk);
    #1;
    if (s == 0) begin b0.memread = 1'b0; b0.memwrite = 1'b0; end
    else begin b1.memread = 1'b0; b1.memwrite = 1'b0; end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    last[0] = '0;
    last[1] = '0;
    b0.memread = 0; b0.memwrite = 0; b0.addr = 0; b0.writedata = 0;
    b1.memread = 0; b1.memwrite = 0; b1.addr = 0; b1.writedata = 0;
    idle(3);
    chk("rst_stall", {31'b0, b0.stall}, 0);
    chk("rst_readdata", b0.readdata, 0);
    chk("rst_err", {31'b0, b0.err}, 0);
    reset = 1'b0;
    idle(2);
    acc(0, 0, 1, 32'h000, 32'h0BADF00D, 0, 0, WB ? 0 : 3); idle(5);
    acc(0, 0, 1, 32'h010, 32'hDEADBEEF, 0, 0, WB ? 0 : 3); idle(5);
    acc(0, 1, 0, 32'h010, 0, 32'hDEADBEEF, 0, 3); idle(2);
    acc(0, 1, 0, 32'h013, 0, 32'h0, 1, 3); idle(2);
    acc(0, 1, 0, 32'h010, 0, 32'hDEADBEEF, 0, 3); idle(2);
    acc(0, 0, 1, 32'h400, 32'h12345678, 0, 1, WB ? 0 : 3); idle(5);
    acc(0, 1, 0, 32'h000, 0, 32'h0BADF00D, 0, 3); idle(2);
    acc(0, 1, 0, 32'h400, 0, 32'h0, 1, 3); idle(2);
    acc(0, 0, 1, 32'h3FC, 32'hFFFF0001, 0, 0, WB ? 0 : 3); idle(5);
    acc(0, 1, 0, 32'h3FC, 0, 32'hFFFF0001, 0, 3); idle(2);
    acc(0, 1, 1, 32'h024, 32'h00000055, 0, 0, WB ? 0 : 3); idle(5);
    acc(0, 1, 0, 32'h024, 0, 32'h00000055, 0, 3); idle(2);
    acc(0, 0, 1, 32'h020, 32'h11112222, 0, 0, WB ? 0 : 3); idle(5);
    acc(0, 1, 0, 32'h020, 0, 32'h11112222, 0, 3); idle(2);
    b0.memwrite = 1'b1; b0.addr = 32'h020; b0.writedata = 32'hCAFEF00D;
    idle(1);
    reset = 1'b1;
    b0.memwrite = 1'b0;
    idle(1);
    chk("midrst_stall", {31'b0, b0.stall}, 0);
    chk("midrst_readdata", b0.readdata, 0);
    chk("midrst_err", {31'b0, b0.err}, 0);
    reset = 1'b0;
    last[0] = '0;
    idle(2);
    acc(0, 1, 0, 32'h020, 0, 32'h11112222, 0, 3); idle(2);
`ifdef DMEM_WBUF_EN
    acc(0, 0, 1, 32'h008, 32'hA5A5A5A5, 0, 0, 0);
    acc(0, 1, 0, 32'h008, 0, 32'hA5A5A5A5, 0, 6); idle(2);
`endif
    acc(1, 0, 1, 32'h000, 32'h600D0000, 0, 0, WB ? 0 : 1); idle(3);
    acc(1, 0, 1, 32'h004, 32'h600D0004, 0, 0, WB ? 0 : 1); idle(3);
    b1.memread = 1'b1;
    b1.addr = 32'h0;
    push(1, 32'h600D0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("alt_stall%0d", i), {31'b0, b1.stall}, 32'(i % 2 == 0));
      if (i % 2 == 1) begin
        @(posedge clk);
        #1;
        if (i < 7) begin
          b1.addr = (i / 2) % 2 == 0 ? 32'h4 : 32'h0;
          push(1, (i / 2) % 2 == 0 ? 32'h600D0004 : 32'h600D0000, 1'b0);
        end else b1.memread = 1'b0;
      end
    end
    idle(5);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
